// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the instruction/data memory-port arbiter.
package mem_arb_pkg;

  // Arbiter sequencing states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    WAIT_R = 2'd2,
    RETIRE = 2'd3
  } arb_state_e;

  // Port owner encoding
  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

  // Every memory beat moves one 64-bit word
  localparam int BEAT_BYTES = 8;
  localparam int BEAT_OFF_W = $clog2(BEAT_BYTES);

endpackage

// File: rtl/rr_pick2.sv
// Two-requester round-robin picker: a lone requester always wins; on a tie
// the requester that did not own the port last time wins.
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       gnt_valid,
  output logic       gnt_id
);

  // Decode request pattern into a grant
  always_comb begin
    gnt_valid = 1'b0;
    gnt_id    = 1'b0;
    case (req)
      2'b01: begin
        gnt_valid = 1'b1;
        gnt_id    = 1'b0;
      end
      2'b10: begin
        gnt_valid = 1'b1;
        gnt_id    = 1'b1;
      end
      2'b11: begin
        gnt_valid = 1'b1;
        gnt_id    = ~last;
      end
      default: begin
        gnt_valid = 1'b0;
        gnt_id    = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/imem_dmem_arbiter.sv
// Shares one main-memory port between icache line refills and dcache line
// fills/writebacks. A granted transaction runs as a BEATS-long burst of
// single-outstanding 64-bit beats; memory-side controls are registered while
// the per-beat handshakes back to the caches are combinational.
module imem_dmem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int BEATS  = 4,
  parameter int ADDR_W = 64
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              IC_REQ,
  input  logic [ADDR_W-1:0] IC_ADDR,
  output logic              IC_RVALID,
  output logic [63:0]       IC_RDATA,
  output logic              IC_DONE,
  input  logic              DC_REQ,
  input  logic              DC_WE,
  input  logic [ADDR_W-1:0] DC_ADDR,
  input  logic [63:0]       DC_WDATA,
  output logic              DC_WREADY,
  output logic              DC_RVALID,
  output logic [63:0]       DC_RDATA,
  output logic              DC_DONE,
  output logic              MEM_REQ,
  output logic              MEM_WE,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic [63:0]       MEM_WDATA,
  input  logic              MEM_GNT,
  input  logic              MEM_RVALID,
  input  logic [63:0]       MEM_RDATA,
  output logic              BUSY
);

  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
  localparam logic [ADDR_W-1:0] LINE_MASK = ~(ADDR_W'(BEATS * BEAT_BYTES - 1));

  // Transaction state
  arb_state_e        r_state;
  owner_e            r_owner;
  owner_e            r_last_owner;
  logic              r_we;
  logic [ADDR_W-1:0] r_base;
  logic [BEAT_W-1:0] r_beat;
  logic              r_mem_req;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;

  // Grant decode and beat datapath
  logic              w_gnt_valid;
  logic              w_gnt_id;
  owner_e            w_gnt_owner;
  logic              w_gnt_we;
  logic [ADDR_W-1:0] w_gnt_base;
  logic [BEAT_W-1:0] w_beat_nxt;
  logic              w_last_beat;
  logic              w_own_d;
  logic              w_beat_acc;
  logic              w_wr_beat;
  logic              w_rd_beat;

  // Bursts never leave the line, so the beat offset is OR-ed into the base
  function automatic logic [ADDR_W-1:0] f_beat_addr(input logic [ADDR_W-1:0] base,
                                                    input logic [BEAT_W-1:0] beat);
    return base | ADDR_W'({beat, {BEAT_OFF_W{1'b0}}});
  endfunction

  rr_pick2 u_pick (
    .req       ({DC_REQ, IC_REQ}),
    .last      (r_last_owner == OWN_D),
    .gnt_valid (w_gnt_valid),
    .gnt_id    (w_gnt_id)
  );

  // Select the winner's write flag and line base (icache is always a read)
  always_comb begin
    w_gnt_owner = owner_e'(w_gnt_id);
    w_gnt_we    = 1'b0;
    w_gnt_base  = '0;
    if (w_gnt_owner == OWN_D) begin
      w_gnt_we   = DC_WE;
      w_gnt_base = DC_ADDR & LINE_MASK;
    end else begin
      w_gnt_we   = 1'b0;
      w_gnt_base = IC_ADDR & LINE_MASK;
    end
  end

  assign w_beat_nxt  = r_beat + BEAT_W'(1);
  assign w_last_beat = (r_beat == LAST_BEAT);
  assign w_own_d     = (r_owner == OWN_D);
  // MEM_REQ is always high in ISSUE, so a GNT there is a real acceptance
  assign w_beat_acc  = (r_state == ISSUE) && MEM_GNT;
  assign w_wr_beat   = w_beat_acc && r_we;
  // Read data only counts while a read beat is outstanding
  assign w_rd_beat   = (r_state == WAIT_R) && MEM_RVALID;

  // Arbitration FSM with beat counter, transaction latches and registered memory controls
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state      <= IDLE;
      r_owner      <= OWN_I;
      r_last_owner <= OWN_I;
      r_we         <= 1'b0;
      r_base       <= '0;
      r_beat       <= '0;
      r_mem_req    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_gnt_valid) begin
            r_owner      <= w_gnt_owner;
            r_last_owner <= w_gnt_owner;
            r_we         <= w_gnt_we;
            r_base       <= w_gnt_base;
            r_beat       <= '0;
            r_mem_req    <= 1'b1;
            r_mem_we     <= w_gnt_we;
            r_mem_addr   <= w_gnt_base;
            r_state      <= ISSUE;
          end else begin
            r_state <= IDLE;
          end
        end
        ISSUE: begin
          if (MEM_GNT) begin
            if (r_we) begin
              if (w_last_beat) begin
                r_mem_req  <= 1'b0;
                r_mem_we   <= 1'b0;
                r_mem_addr <= '0;
                r_state    <= RETIRE;
              end else begin
                r_beat     <= w_beat_nxt;
                r_mem_addr <= f_beat_addr(r_base, w_beat_nxt);
                r_state    <= ISSUE;
              end
            end else begin
              r_mem_req  <= 1'b0;
              r_mem_we   <= 1'b0;
              r_mem_addr <= '0;
              r_state    <= WAIT_R;
            end
          end else begin
            r_state <= ISSUE;
          end
        end
        WAIT_R: begin
          if (MEM_RVALID) begin
            if (w_last_beat) begin
              r_state <= RETIRE;
            end else begin
              r_beat     <= w_beat_nxt;
              r_mem_req  <= 1'b1;
              r_mem_we   <= r_we;
              r_mem_addr <= f_beat_addr(r_base, w_beat_nxt);
              r_state    <= ISSUE;
            end
          end else begin
            r_state <= WAIT_R;
          end
        end
        RETIRE: begin
          // Requester gets this cycle to drop REQ before IDLE samples again
          r_state <= IDLE;
        end
        default: begin
          r_mem_req  <= 1'b0;
          r_mem_we   <= 1'b0;
          r_mem_addr <= '0;
          r_state    <= IDLE;
        end
      endcase
    end
  end

  assign MEM_REQ   = r_mem_req;
  assign MEM_WE    = r_mem_we;
  assign MEM_ADDR  = r_mem_addr;
  assign MEM_WDATA = (w_own_d && r_we) ? DC_WDATA : 64'd0;
  assign BUSY      = (r_state != IDLE);

  assign IC_RVALID = w_rd_beat && !w_own_d;
  assign IC_RDATA  = IC_RVALID ? MEM_RDATA : 64'd0;
  assign IC_DONE   = IC_RVALID && w_last_beat;

  assign DC_WREADY = w_wr_beat && w_own_d;
  assign DC_RVALID = w_rd_beat && w_own_d;
  assign DC_RDATA  = DC_RVALID ? MEM_RDATA : 64'd0;
  assign DC_DONE   = (DC_RVALID || DC_WREADY) && w_last_beat;

endmodule

// File: doc/imem_dmem_arbiter.md
# imem_dmem_arbiter

Shares the single main-memory port between the instruction cache line refill (fetch stage) and the data cache (mem stage). Arbitration is round-robin. Each granted transaction is sequenced as a BEATS-long burst of single-outstanding 64-bit beats. The block sits between `instruction_cache`/data cache and the memory model/controller. Its DONE pulses are what release the fetch stage's icache-not-ready condition and the mem stage's `mem_stall`.

## Interface
- BEATS, 4: beats per line transfer (line = BEATS*8 bytes, power of two ≥2)
- ADDR_W, 64: address width

Ports:
- CLK  in  1  clock, all state on rising edge
- RESET_N  in  1  asynchronous, active-low reset
- IC_REQ  in  1  icache refill request; held until IC_DONE
- IC_ADDR  in  ADDR_W  refill address; low log2(BEATS*8) bits ignored
- IC_RVALID  out  1  beat of refill data valid
- IC_RDATA  out  64  refill beat data
- IC_DONE  out  1  one-cycle pulse on final refill beat
- DC_REQ  in  1  dcache request; held until DC_DONE
- DC_WE  in  1  1 = line writeback, 0 = line fill
- DC_ADDR  in  ADDR_W  line address; low bits ignored
- DC_WDATA  in  64  current writeback beat
- DC_WREADY  out  1  current DC_WDATA consumed; dcache advances to next beat
- DC_RVALID  out  1  fill beat valid
- DC_RDATA  out  64  fill beat data
- DC_DONE  out  1  one-cycle pulse on final beat (read or write)
- MEM_REQ  out  1  beat request
- MEM_WE  out  1  beat is a write
- MEM_ADDR  out  ADDR_W  beat address
- MEM_WDATA  out  64  write beat data
- MEM_GNT  in  1  memory accepts beat this cycle
- MEM_RVALID  in  1  read beat data returned
- MEM_RDATA  in  64  read data
- BUSY  out  1  transaction in progress (state ≠ IDLE)

## Operation
- States: IDLE, ISSUE, WAIT_R, RETIRE.
- **IDLE:**
  - Sample IC_REQ/DC_REQ.
  - One requester → grant it.
  - Both requesting → grant the one not in `last_owner`.
  - On grant: latch owner, WE (I-side always read), and line base = ADDR with low bits cleared.
  - Clear beat counter, set `last_owner`, go to ISSUE.
- **ISSUE:**
  - MEM_REQ=1, MEM_WE=latched WE, MEM_ADDR=base + beat*8.
  - On MEM_GNT, read → WAIT_R.
  - On MEM_GNT, write → DC_WREADY=1 the same cycle. If last beat, DC_DONE=1 and go to RETIRE; otherwise increment beat and stay in ISSUE.
- **WAIT_R:**
  - MEM_REQ=0.
  - On MEM_RVALID: owner's RVALID=1, RDATA=MEM_RDATA.
  - If last beat, owner's DONE=1 and go to RETIRE; otherwise increment beat and go to ISSUE.
- **RETIRE:** one cycle, no request sampled, then IDLE. This gives the requester one cycle to drop REQ.
- Beat counter is log2(BEATS) bits. Address arithmetic is modulo 2^ADDR_W, and bursts never cross the line.
- MEM_WDATA = DC_WDATA combinationally whenever the owner is D and WE=1; otherwise 0.
- RDATA outputs pass MEM_RDATA through and are 0 when their RVALID is low.
- Ignored inputs: MEM_RVALID outside WAIT_R, and MEM_GNT while MEM_REQ=0.
- REQ dropping while owner: the transaction still completes (no abort).

## Timing
- **Reset:** state IDLE, beat 0, `last_owner`=I (first tie goes to D). All outputs 0, including MEM_ADDR=0 and BUSY=0.
- **Reset mid-burst:** the transaction is abandoned immediately. A late MEM_RVALID after release lands in IDLE and is dropped.
- **Grant latency:** REQ high in IDLE at cycle t → MEM_REQ high at t+1.
- **Control outputs:** MEM_REQ/MEM_WE/MEM_ADDR are registered (state-derived).
- **Combinational outputs:** DC_WREADY, *_RVALID and *_DONE are combinational from MEM_GNT/MEM_RVALID.
- **Minimum read burst:** BEATS*2 + 2 cycles, request to IDLE, with zero-wait memory: grant cycle + (ISSUE + WAIT_R)×BEATS + RETIRE.
- **Minimum write burst:** BEATS + 2 cycles.
- **Back-to-back:** at least two non-requesting cycles (RETIRE, then IDLE) separate transactions. Under continuous dual requests, grants alternate I, D, I, D.

## Structure
- Shared package `mem_arb_pkg`:
  - state enum (IDLE/ISSUE/WAIT_R/RETIRE)
  - owner encoding (OWN_I=0, OWN_D=1)
  - BEAT_BYTES=8 constant
- One sub-module `rr_pick2`: combinational two-requester round-robin picker, with inputs req[1:0] and last, outputs gnt_valid and gnt_id.
- FSM, counter and latches live in the top module.

## Test plan
- **Single icache refill:** IC_REQ, IC_ADDR=0x1013, zero-wait memory.
  - MEM_ADDR = 0x1000, 0x1008, 0x1010, 0x1018.
  - Four IC_RVALID pulses; IC_DONE on the 4th; BUSY low 10 cycles after request.
- **Dcache writeback:** DC_WE=1, DC_ADDR=0x2000, MEM_GNT delayed 3 cycles per beat.
  - DC_WREADY exactly on each MEM_GNT.
  - MEM_WDATA tracks DC_WDATA; DC_DONE with the 4th GNT.
- **Simultaneous IC_REQ/DC_REQ out of reset:**
  - D granted first, I next.
  - With both held continuously, the owner sequence is D, I, D, I.
- **Stray memory responses:** MEM_RVALID pulsed in IDLE and in ISSUE → no RVALID/DONE on either side, beat counter unchanged.
- **Reset mid-burst:** assert RESET_N=0 after beat 2 of an icache refill.
  - All outputs 0 asynchronously.
  - After release, a pending MEM_RVALID is dropped; a new DC_REQ is granted normally.
- **REQ dropped mid-transaction:** IC_REQ falls after beat 1 → burst completes all 4 beats and IC_DONE still pulses.
